gemm_inst_sequencer: RTL and testbench

Parametrised instruction sequencer that fetches 32-bit LD/ST/GEMM/DRAINSYS instructions from instruction memory and drives the systolic_array_top control and SRAM ports.
- Generalises the previous reader: adds start/busy/done handshake, per-buffer auto-increment pointers, a data-memory interface for LD/ST, GEMM length K, and error flagging.
- Sits between instruction memory / data memory and systolic_array_top.
- All array-facing outputs are registered.

---
 rtl/gemm_isa_pkg.sv | 17 +
 rtl/gemm_phase_counter.sv | 18 +
 rtl/gemm_inst_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_gemm_inst_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_isa_pkg.sv
// gemm_isa_pkg: shared instruction field positions, opcodes, buffer ids and array control codes
package gemm_isa_pkg;
  localparam int OPC_LSB = 28;
  localparam int BUF_LSB = 26;
  localparam int LOC_LSB = 0;
  localparam logic [3:0] OP_LD = 4'd2;
  localparam logic [3:0] OP_ST = 4'd3;
  localparam logic [3:0] OP_GEMM = 4'd4;
  localparam logic [3:0] OP_DRAINSYS = 4'd5;
  localparam logic [3:0] CTRL_IDLE = 4'd0;
  localparam logic [3:0] CTRL_WARMUP = 4'd1;
  localparam logic [3:0] CTRL_STEADY = 4'd2;
  localparam logic [3:0] CTRL_DRAIN = 4'd3;
  localparam logic [1:0] BUF_TOP = 2'd0;
  localparam logic [1:0] BUF_LEFT = 2'd1;
  localparam logic [1:0] BUF_DOWN = 2'd2;
endpackage

// File: rtl/gemm_phase_counter.sv
// gemm_phase_counter: loadable down-counter; tc marks the last cycle of a phase
module gemm_phase_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !tc) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/gemm_inst_sequencer.sv
// gemm_inst_sequencer: fetches LD/ST/GEMM/DRAINSYS instructions and drives the systolic array control and SRAM ports
module gemm_inst_sequencer
  import gemm_isa_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int BUF_ID_WIDTH = 2,
  parameter int MEM_LOC_WIDTH = 26,
  parameter int LOG2_INST_MEMORY_SIZE = 12,
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_SRAM_BANK_DEPTH = 4,
  parameter int SRAM_BANK_DEPTH = 16,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0] inst_base_addr,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0] inst_count,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             o_inst_rd_en,
  output logic [LOG2_INST_MEMORY_SIZE-1:0] o_inst_rd_addr,
  input  logic [INST_WIDTH-1:0]            i_inst_rd_data,
  output logic                             o_dmem_rd_en,
  output logic [MEM_LOC_WIDTH-1:0]         o_dmem_rd_addr,
  input  logic [NUM_COL*DATA_WIDTH-1:0]    i_dmem_rd_data,
  output logic                             o_dmem_wr_en,
  output logic [MEM_LOC_WIDTH-1:0]         o_dmem_wr_addr,
  output logic [NUM_COL*DATA_WIDTH-1:0]    o_dmem_wr_data,
  output logic                             o_top_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_top_wr_addr,
  output logic [NUM_COL*DATA_WIDTH-1:0]    o_top_wr_data,
  output logic                             o_left_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_left_wr_addr,
  output logic [NUM_ROW*DATA_WIDTH-1:0]    o_left_wr_data,
  output logic                             o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_down_rd_addr,
  input  logic [NUM_COL*DATA_WIDTH-1:0]    i_down_rd_data,
  output logic [CTRL_WIDTH-1:0]            o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_down_sram_rd_end_addr
);
  localparam int KW = LOG2_SRAM_BANK_DEPTH + 1;
  localparam int CW = $clog2(SRAM_BANK_DEPTH + NUM_ROW + NUM_COL) + 1;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LD_RD, S_LD_WR, S_ST_RD, S_ST_WR, S_WARM, S_STEADY, S_DRAIN, S_NEXT
  } state_t;
  state_t state, state_d;
  logic [LOG2_INST_MEMORY_SIZE-1:0] pc, remaining;
  logic [MEM_LOC_WIDTH-1:0] loc;
  logic [BUF_ID_WIDTH-1:0] bid;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] top_ptr, left_ptr, down_ptr;
  logic [OPCODE_WIDTH-1:0] op;
  logic [BUF_ID_WIDTH-1:0] bid_in;
  logic [MEM_LOC_WIDTH-1:0] loc_in;
  logic [KW-1:0] k_in, k_lat;
  logic ld_ok, st_ok, gm_ok, dr_ok, tc, cnt_load;
  logic [CW-1:0] cnt_val;
  assign op = i_inst_rd_data[OPC_LSB +: OPCODE_WIDTH];
  assign bid_in = i_inst_rd_data[BUF_LSB +: BUF_ID_WIDTH];
  assign loc_in = i_inst_rd_data[LOC_LSB +: MEM_LOC_WIDTH];
  assign k_in = loc_in[KW-1:0];
  assign k_lat = loc[KW-1:0];
  assign ld_ok = op == OP_LD && (bid_in == BUF_TOP || bid_in == BUF_LEFT);
  assign st_ok = op == OP_ST && bid_in == BUF_DOWN;
  assign gm_ok = op == OP_GEMM && k_in != '0 && k_in <= KW'(SRAM_BANK_DEPTH);
  assign dr_ok = op == OP_DRAINSYS;
  // one counter times both STEADY (loaded in WARM) and DRAIN (loaded in DECODE)
  assign cnt_load = (state == S_DECODE && dr_ok) || state == S_WARM;
  assign cnt_val = state == S_WARM ? CW'(k_lat - 1'b1) : CW'(NUM_ROW + NUM_COL - 1);
  gemm_phase_counter #(.W(CW)) u_phase (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val(cnt_val),
    .en(state == S_STEADY || state == S_DRAIN), .tc(tc)
  );
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = start && inst_count != '0 ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = ld_ok ? S_LD_RD : st_ok ? S_ST_RD : gm_ok ? S_WARM : dr_ok ? S_DRAIN : S_NEXT;
      S_LD_RD:  state_d = S_LD_WR;
      S_LD_WR:  state_d = S_NEXT;
      S_ST_RD:  state_d = S_ST_WR;
      S_ST_WR:  state_d = S_NEXT;
      S_WARM:   state_d = S_STEADY;
      S_STEADY: state_d = tc ? S_NEXT : S_STEADY;
      S_DRAIN:  state_d = tc ? S_NEXT : S_DRAIN;
      S_NEXT:   state_d = remaining == LOG2_INST_MEMORY_SIZE'(1) ? S_IDLE : S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      {pc, remaining, loc, bid, top_ptr, left_ptr, down_ptr} <= '0;
      {busy, done, err, o_inst_rd_en, o_inst_rd_addr, o_dmem_rd_en, o_dmem_rd_addr} <= '0;
      {o_dmem_wr_en, o_dmem_wr_addr, o_dmem_wr_data} <= '0;
      {o_top_wr_en, o_top_wr_addr, o_top_wr_data, o_left_wr_en, o_left_wr_addr, o_left_wr_data} <= '0;
      {o_down_rd_en, o_down_rd_addr, o_ctrl_state} <= '0;
      {o_top_sram_rd_start_addr, o_top_sram_rd_end_addr, o_left_sram_rd_start_addr} <= '0;
      {o_left_sram_rd_end_addr, o_down_sram_rd_start_addr, o_down_sram_rd_end_addr} <= '0;
    end else begin
      state <= state_d;
      {done, o_inst_rd_en, o_dmem_rd_en, o_dmem_wr_en, o_top_wr_en, o_left_wr_en, o_down_rd_en} <= '0;
      case (state)
        S_IDLE: if (start) begin
          err <= 1'b0;
          done <= inst_count == '0;
          if (inst_count != '0) begin
            busy <= 1'b1;
            pc <= inst_base_addr;
            remaining <= inst_count;
            o_inst_rd_en <= 1'b1;
            o_inst_rd_addr <= inst_base_addr;
          end
        end
        S_DECODE: begin
          loc <= loc_in;
          bid <= bid_in;
          if (!(ld_ok || st_ok || gm_ok || dr_ok)) err <= 1'b1;
          if (ld_ok) begin
            o_dmem_rd_en <= 1'b1;
            o_dmem_rd_addr <= loc_in;
          end
          if (st_ok) begin
            o_down_rd_en <= 1'b1;
            o_down_rd_addr <= down_ptr;
          end
          if (gm_ok) begin
            o_ctrl_state <= CTRL_WARMUP;
            o_top_sram_rd_start_addr <= '0;
            o_left_sram_rd_start_addr <= '0;
            o_top_sram_rd_end_addr <= LOG2_SRAM_BANK_DEPTH'(k_in - 1'b1);
            o_left_sram_rd_end_addr <= LOG2_SRAM_BANK_DEPTH'(k_in - 1'b1);
            top_ptr <= '0;
            left_ptr <= '0;
          end
          if (dr_ok) begin
            o_ctrl_state <= CTRL_DRAIN;
            o_down_sram_rd_start_addr <= '0;
            o_down_sram_rd_end_addr <= LOG2_SRAM_BANK_DEPTH'(NUM_COL - 1);
            down_ptr <= '0;
          end
        end
        S_LD_WR: if (bid == BUF_TOP) begin
          o_top_wr_en <= 1'b1;
          o_top_wr_addr <= top_ptr;
          o_top_wr_data <= i_dmem_rd_data;
          top_ptr <= top_ptr + 1'b1;
        end else begin
          o_left_wr_en <= 1'b1;
          o_left_wr_addr <= left_ptr;
          o_left_wr_data <= i_dmem_rd_data[NUM_ROW*DATA_WIDTH-1:0];
          left_ptr <= left_ptr + 1'b1;
        end
        S_ST_WR: begin
          o_dmem_wr_en <= 1'b1;
          o_dmem_wr_addr <= loc;
          o_dmem_wr_data <= i_down_rd_data;
          down_ptr <= down_ptr + 1'b1;
        end
        S_WARM: o_ctrl_state <= CTRL_STEADY;
        S_STEADY, S_DRAIN: if (tc) o_ctrl_state <= CTRL_IDLE;
        S_NEXT: begin
          pc <= pc + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == LOG2_INST_MEMORY_SIZE'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            o_inst_rd_en <= 1'b1;
            o_inst_rd_addr <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// tb_gemm_inst_sequencer: scoreboard bench for the instruction sequencer
module tb_gemm_inst_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [11:0] inst_base_addr = '0, inst_count = '0;
  logic busy, done, err;
  logic o_inst_rd_en;
  logic [11:0] o_inst_rd_addr;
  logic [31:0] i_inst_rd_data = '0;
  logic o_dmem_rd_en, o_dmem_wr_en;
  logic [25:0] o_dmem_rd_addr, o_dmem_wr_addr;
  logic [63:0] i_dmem_rd_data = '0, o_dmem_wr_data;
  logic o_top_wr_en, o_left_wr_en, o_down_rd_en;
  logic [3:0] o_top_wr_addr, o_left_wr_addr, o_down_rd_addr;
  logic [63:0] o_top_wr_data, o_left_wr_data, i_down_rd_data = '0;
  logic [3:0] o_ctrl_state;
  logic [3:0] t_s, t_e, l_s, l_e, d_s, d_e;
  int total = 0, bad = 0;
  logic [31:0] imem [0:4095];
  logic [63:0] dmem [0:63];
  logic [11:0] exp_inst [$];
  logic [67:0] exp_top [$], exp_left [$];
  logic [89:0] exp_dwr [$];
  logic [11:0] exp_ctrl [$];
  logic [11:0] wp;
  int cyc, ninst;
  logic exp_err;
  logic [3:0] tptr = '0, lptr = '0, dptr = '0, tend = '0, dend = '0;
  logic [3:0] cur_ctrl = '0;
  int cur_len = 0;
  logic any_out;

  gemm_inst_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .inst_base_addr(inst_base_addr), .inst_count(inst_count),
    .busy(busy), .done(done), .err(err),
    .o_inst_rd_en(o_inst_rd_en), .o_inst_rd_addr(o_inst_rd_addr), .i_inst_rd_data(i_inst_rd_data),
    .o_dmem_rd_en(o_dmem_rd_en), .o_dmem_rd_addr(o_dmem_rd_addr), .i_dmem_rd_data(i_dmem_rd_data),
    .o_dmem_wr_en(o_dmem_wr_en), .o_dmem_wr_addr(o_dmem_wr_addr), .o_dmem_wr_data(o_dmem_wr_data),
    .o_top_wr_en(o_top_wr_en), .o_top_wr_addr(o_top_wr_addr), .o_top_wr_data(o_top_wr_data),
    .o_left_wr_en(o_left_wr_en), .o_left_wr_addr(o_left_wr_addr), .o_left_wr_data(o_left_wr_data),
    .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr), .i_down_rd_data(i_down_rd_data),
    .o_ctrl_state(o_ctrl_state),
    .o_top_sram_rd_start_addr(t_s), .o_top_sram_rd_end_addr(t_e),
    .o_left_sram_rd_start_addr(l_s), .o_left_sram_rd_end_addr(l_e),
    .o_down_sram_rd_start_addr(d_s), .o_down_sram_rd_end_addr(d_e)
  );

  assign any_out = |{busy, done, err, o_inst_rd_en, o_inst_rd_addr, o_dmem_rd_en, o_dmem_rd_addr,
                     o_dmem_wr_en, o_dmem_wr_addr, o_dmem_wr_data, o_top_wr_en, o_top_wr_addr, o_top_wr_data,
                     o_left_wr_en, o_left_wr_addr, o_left_wr_data, o_down_rd_en, o_down_rd_addr,
                     o_ctrl_state, t_s, t_e, l_s, l_e, d_s, d_e};

  always #5 clk = ~clk;

  function automatic logic [63:0] down_word(input logic [3:0] a);
    return {4{12'hD00, a}};
  endfunction

  always @(posedge clk) begin
    if (o_inst_rd_en) i_inst_rd_data <= imem[o_inst_rd_addr];
    if (o_dmem_rd_en) i_dmem_rd_data <= dmem[o_dmem_rd_addr[5:0]];
    if (o_down_rd_en) i_down_rd_data <= down_word(o_down_rd_addr);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event unexpected or missing", nm);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cur_ctrl = '0;
      cur_len = 0;
    end else begin
      if (o_inst_rd_en) begin
        if (exp_inst.size() == 0) flag("inst_fetch");
        else chk("inst_addr", o_inst_rd_addr, exp_inst.pop_front());
      end
      if (o_top_wr_en) begin
        if (exp_top.size() == 0) flag("top_wr");
        else chk("top_wr", {o_top_wr_addr, o_top_wr_data}, exp_top.pop_front());
      end
      if (o_left_wr_en) begin
        if (exp_left.size() == 0) flag("left_wr");
        else chk("left_wr", {o_left_wr_addr, o_left_wr_data}, exp_left.pop_front());
      end
      if (o_dmem_wr_en) begin
        if (exp_dwr.size() == 0) flag("dmem_wr");
        else chk("dmem_wr", {o_dmem_wr_addr, o_dmem_wr_data}, exp_dwr.pop_front());
      end
      if (o_ctrl_state == cur_ctrl) cur_len++;
      else begin
        if (cur_ctrl != '0) begin
          if (exp_ctrl.size() == 0) flag("ctrl_seg");
          else chk("ctrl_seg", {cur_ctrl, 8'(cur_len)}, exp_ctrl.pop_front());
        end
        cur_ctrl = o_ctrl_state;
        cur_len = 1;
      end
    end
  end

  task automatic prog(input logic [11:0] base);
    wp = base;
    cyc = 0;
    ninst = 0;
    exp_err = 1'b0;
  endtask

  task automatic add(input logic [3:0] op, input logic [1:0] b, input logic [25:0] loc);
    logic [4:0] k;
    k = loc[4:0];
    imem[wp] = {op, b, loc};
    exp_inst.push_back(wp);
    wp = wp + 1'b1;
    ninst++;
    if (op == 4'd2 && b < 2'd2) begin
      if (b == 2'd0) begin
        exp_top.push_back({tptr, dmem[loc[5:0]]});
        tptr++;
      end else begin
        exp_left.push_back({lptr, dmem[loc[5:0]]});
        lptr++;
      end
      cyc += 5;
    end else if (op == 4'd3 && b == 2'd2) begin
      exp_dwr.push_back({loc, down_word(dptr)});
      dptr++;
      cyc += 5;
    end else if (op == 4'd4 && k >= 5'd1 && k <= 5'd16) begin
      exp_ctrl.push_back({4'd1, 8'd1});
      exp_ctrl.push_back({4'd2, 3'd0, k});
      tptr = '0;
      lptr = '0;
      tend = 4'(k - 5'd1);
      cyc += int'(k) + 4;
    end else if (op == 4'd5) begin
      exp_ctrl.push_back({4'd3, 8'd8});
      dptr = '0;
      dend = 4'd3;
      cyc += 11;
    end else begin
      exp_err = 1'b1;
      cyc += 3;
    end
  endtask

  task automatic run(input logic [11:0] base, input string nm, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    inst_base_addr = base;
    inst_count = 12'(ninst);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, "_busy_start"}, busy, ninst != 0);
    chk({nm, "_err_clear"}, err, 1'b0);
    while (!done && n < 2000) begin
      start = poke && n == 3;
      if (poke) inst_base_addr = base + 12'd7;
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
    if (!done) flag({nm, "_timeout"});
    else chk({nm, "_cycles"}, n, cyc);
    chk({nm, "_busy_end"}, busy, 1'b0);
    chk({nm, "_err"}, err, exp_err);
  endtask

  task automatic check_win();
    chk("top_start", t_s, 4'd0);
    chk("top_end", t_e, tend);
    chk("left_start", l_s, 4'd0);
    chk("left_end", l_e, tend);
    chk("down_start", d_s, 4'd0);
    chk("down_end", d_e, dend);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) dmem[i] = {4{16'(16'h1000 + i)}};
    dmem[16] = {4{16'hAAAA}};
    dmem[17] = {4{16'hBBBB}};
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", any_out, 1'b0);
    rst = 1'b0;
    prog(12'h000);
    run(12'h000, "empty", 1'b0);
    prog(12'h010);
    add(4'd2, 2'd0, 26'h10);
    add(4'd2, 2'd0, 26'h11);
    run(12'h010, "ld2", 1'b0);
    prog(12'h020);
    add(4'd2, 2'd0, 26'h12);
    add(4'd4, 2'd0, 26'd3);
    add(4'd2, 2'd0, 26'h13);
    add(4'd2, 2'd1, 26'h14);
    run(12'h020, "gemm", 1'b0);
    check_win();
    prog(12'h030);
    add(4'd5, 2'd0, 26'd0);
    add(4'd3, 2'd2, 26'h20);
    run(12'h030, "drain_st", 1'b0);
    check_win();
    prog(12'h040);
    add(4'hF, 2'd0, 26'd0);
    add(4'd4, 2'd0, 26'd0);
    add(4'd2, 2'd2, 26'd5);
    add(4'd4, 2'd0, 26'd17);
    run(12'h040, "illegal", 1'b0);
    prog(12'h050);
    for (int i = 0; i < 17; i++) add(4'd2, 2'd1, 26'(i));
    run(12'h050, "ld17", 1'b0);
    prog(12'hFFF);
    add(4'd2, 2'd0, 26'd1);
    add(4'd2, 2'd0, 26'd2);
    run(12'hFFF, "pc_wrap", 1'b0);
    prog(12'h100);
    add(4'd4, 2'd0, 26'd8);
    @(negedge clk);
    inst_base_addr = 12'h100;
    inst_count = 12'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (o_ctrl_state != 4'd2 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (o_ctrl_state != 4'd2) flag("steady_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    exp_ctrl.delete();
    @(posedge clk);
    #1 chk("mid_reset_outputs", any_out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    {tptr, lptr, dptr, tend, dend} = '0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("no_done_after_reset", done, 1'b0);
    end
    check_win();
    prog(12'h200);
    add(4'd2, 2'd0, 26'h11);
    add(4'd2, 2'd1, 26'h12);
    add(4'd3, 2'd2, 26'h21);
    run(12'h200, "post_reset", 1'b1);
    repeat (2) @(posedge clk);
    chk("queues_drained", exp_inst.size() + exp_top.size() + exp_left.size() + exp_dwr.size() + exp_ctrl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
